// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM encoding and
// the byte/half lane extract/merge helpers used by the alignment logic.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_RESP
  } state_t;

  // Misaligned halves/words and the unused funct3 codes are rejected.
  function automatic logic access_err(input logic [2:0] f3, input logic [1:0] off);
    logic err;
    case (f3)
      F3_B, F3_BU: err = 1'b0;
      F3_H, F3_HU: err = off[0];
      F3_W:        err = (off != 2'b00);
      default:     err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      F3_B:    res = {{24{b[7]}}, b};
      F3_BU:   res = {24'h0, b};
      F3_H:    res = {{16{h[15]}}, h};
      F3_HU:   res = {16'h0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Size comes from funct3[1:0]; only the addressed lane is replaced.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] data,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  off);
    logic [31:0] res;
    res = word;
    case (f3[1:0])
      2'b00:   res[{off, 3'b000} +: 8]     = data[7:0];
      2'b01:   res[{off[1], 4'b0000} +: 16] = data[15:0];
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Core request/response handshake plus the word-wide memory port of the LSU.
interface lsu_mem_ctrl_if #(
  parameter int WIDTH   = 32,
  parameter int ADDRESS = 10
);
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [2:0]         req_funct3;
  logic [31:0]        req_addr;
  logic [31:0]        req_wdata;
  logic               rsp_valid;
  logic [31:0]        rsp_rdata;
  logic               rsp_err;
  logic               mem_we;
  logic [ADDRESS-1:0] mem_addr;
  logic [WIDTH-1:0]   mem_wdata;
  logic [WIDTH-1:0]   mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_wdata
  );

  modport mem (
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends load data and merges store data
// into a read word for sub-word read-modify-write.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_data,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  output logic [31:0] o_extract,
  output logic [31:0] o_merge
);

  assign o_extract = lane_extract(i_word, i_funct3, i_off);
  assign o_merge   = lane_merge(i_word, i_data, i_funct3, i_off);

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store initiator: one request per handshake, sub-word stores done as
// read-modify-write, single-cycle response pulse with optional error.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ADDRESS = 10
) (
  input  logic           clk,
  input  logic           reset_n,
  lsu_mem_ctrl_if.slave  bus
);

  state_t             r_state;
  state_t             w_next;
  logic [2:0]         r_funct3;
  logic [ADDRESS+1:0] r_addr;
  logic [WIDTH-1:0]   r_wdata;
  logic [WIDTH-1:0]   r_merge;
  logic [WIDTH-1:0]   r_rdata;
  logic               r_err;

  logic               w_accept;
  logic               w_req_err;
  logic [WIDTH-1:0]   w_extract;
  logic [WIDTH-1:0]   w_merge;

  assign w_accept  = (r_state == S_IDLE) && bus.req_valid;
  assign w_req_err = access_err(bus.req_funct3, bus.req_addr[1:0]);

  lsu_align u_align (
    .i_word    (bus.mem_rdata),
    .i_data    (r_wdata),
    .i_funct3  (r_funct3),
    .i_off     (r_addr[1:0]),
    .o_extract (w_extract),
    .o_merge   (w_merge)
  );

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (w_req_err)                        w_next = S_RESP;
          else if (!bus.req_we)                 w_next = S_LOAD;
          else if (bus.req_funct3[1:0] == 2'b10) w_next = S_WRITE;
          else                                  w_next = S_RMW_RD;
        end
      end
      S_LOAD:   w_next = S_RESP;
      S_RMW_RD: w_next = S_WRITE;
      S_WRITE:  w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_merge  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_funct3 <= bus.req_funct3;
        r_addr   <= bus.req_addr[ADDRESS+1:0];
        r_wdata  <= bus.req_wdata;
        r_rdata  <= '0;
        r_err    <= w_req_err;
      end
      if (r_state == S_LOAD)   r_rdata <= w_extract;
      if (r_state == S_RMW_RD) r_merge <= w_merge;
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.rsp_valid = (r_state == S_RESP);
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
  assign bus.mem_we    = (r_state == S_WRITE);
  assign bus.mem_addr  = r_addr[ADDRESS+1:2];
  // Full-word stores bypass the merge register.
  assign bus.mem_wdata = (r_funct3[1:0] == 2'b10) ? r_wdata : r_merge;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl against a word memory model with
// posedge writes and combinational reads.
module tb_lsu_mem_ctrl;
  import lsu_pkg::*;

  logic clk;
  logic reset_n;
  int   n_asserts;
  int   n_fail;
  int   n_we;

  lsu_mem_ctrl_if #(.WIDTH(32), .ADDRESS(10)) bus ();

  lsu_mem_ctrl #(.WIDTH(32), .ADDRESS(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [31:0] mem [1024];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_addr];

  always @(negedge clk) if (bus.mem_we === 1'b1) n_we++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Issue one request and wait for its response; lat counts cycles after accept.
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int nwe);
    int we_base;
    @(negedge clk);
    check("ready_before_req", {31'b0, bus.req_ready}, 32'd1);
    we_base        = n_we;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    @(posedge clk); #1;
    nwe = n_we - we_base;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          nwe;
  int          pulses;

  initial begin
    n_asserts = 0;
    n_fail    = 0;
    n_we      = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    reset_n        = 1'b0;
    #1;
    check("rst_ready",     {31'b0, bus.req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_rsp_err",   {31'b0, bus.rsp_err}, 32'd0);
    check("rst_mem_we",    {31'b0, bus.mem_we}, 32'd0);
    check("rst_mem_addr",  {22'b0, bus.mem_addr}, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // SW then loads of the stored word
    do_req(1'b1, F3_W, 32'h10, 32'hDEADBEEF, rd, er, lat, nwe);
    check("sw_lat", lat, 2);
    check("sw_err", {31'b0, er}, 32'd0);
    check("sw_nwe", nwe, 1);
    check("sw_mem4", mem[4], 32'hDEADBEEF);

    do_req(1'b0, F3_B, 32'h13, 32'h0, rd, er, lat, nwe);
    check("lb_13", rd, 32'hFFFFFFDE);
    check("lb_lat", lat, 2);
    check("lb_nwe", nwe, 0);
    do_req(1'b0, F3_BU, 32'h13, 32'h0, rd, er, lat, nwe);
    check("lbu_13", rd, 32'h000000DE);

    // SB read-modify-write; upper wdata bits must be ignored
    do_req(1'b1, F3_B, 32'h11, 32'hAAAAAA55, rd, er, lat, nwe);
    check("sb_lat", lat, 3);
    check("sb_nwe", nwe, 1);
    check("sb_rdata", rd, 32'h0);
    check("sb_mem4", mem[4], 32'hDEAD55EF);

    do_req(1'b0, F3_H, 32'h12, 32'h0, rd, er, lat, nwe);
    check("lh_12", rd, 32'hFFFFDEAD);
    do_req(1'b0, F3_HU, 32'h12, 32'h0, rd, er, lat, nwe);
    check("lhu_12", rd, 32'h0000DEAD);
    do_req(1'b0, F3_B, 32'h10, 32'h0, rd, er, lat, nwe);
    check("lb_10", rd, 32'hFFFFFFEF);
    do_req(1'b0, F3_H, 32'h10, 32'h0, rd, er, lat, nwe);
    check("lh_10", rd, 32'h000055EF);
    do_req(1'b0, F3_W, 32'h10, 32'h0, rd, er, lat, nwe);
    check("lw_10", rd, 32'hDEAD55EF);
    check("lw_err", {31'b0, er}, 32'd0);

    // Error responses
    do_req(1'b0, F3_W, 32'h12, 32'h0, rd, er, lat, nwe);
    check("lw_mis_err", {31'b0, er}, 32'd1);
    check("lw_mis_rdata", rd, 32'h0);
    check("lw_mis_lat", lat, 1);
    check("lw_mis_nwe", nwe, 0);
    do_req(1'b0, F3_H, 32'h13, 32'h0, rd, er, lat, nwe);
    check("lh_mis_err", {31'b0, er}, 32'd1);
    do_req(1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat, nwe);
    check("f3_011_err", {31'b0, er}, 32'd1);
    do_req(1'b1, F3_W, 32'h11, 32'h12345678, rd, er, lat, nwe);
    check("sw_mis_err", {31'b0, er}, 32'd1);
    check("sw_mis_nwe", nwe, 0);
    check("sw_mis_mem4", mem[4], 32'hDEAD55EF);
    do_req(1'b1, F3_H, 32'h11, 32'h1234, rd, er, lat, nwe);
    check("sh_mis_lat", lat, 1);
    check("sh_mis_mem4", mem[4], 32'hDEAD55EF);

    // Wrapping SH: 0x1002 maps to word 0, upper half
    do_req(1'b1, F3_W, 32'h0, 32'h11223344, rd, er, lat, nwe);
    do_req(1'b1, F3_H, 32'h1002, 32'hABCD1234, rd, er, lat, nwe);
    check("sh_wrap_err", {31'b0, er}, 32'd0);
    check("sh_wrap_lat", lat, 3);
    check("sh_wrap_mem0", mem[0], 32'h12343344);

    // Reset asserted while in RMW_RD abandons the store
    do_req(1'b1, F3_W, 32'h20, 32'hCAFEF00D, rd, er, lat, nwe);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_B;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h77;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    reset_n       = 1'b0;
    #1;
    check("rst_mid_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_mid_mem_we", {31'b0, bus.mem_we}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("rst_mid_mem8", mem[8], 32'hCAFEF00D);
    do_req(1'b0, F3_W, 32'h20, 32'h0, rd, er, lat, nwe);
    check("rst_mid_lw", rd, 32'hCAFEF00D);

    // Back-to-back: req_valid held high yields one response per three cycles
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h10;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) begin
        pulses++;
        check("b2b_rdata", bus.rsp_rdata, 32'hDEAD55EF);
      end
    end
    bus.req_valid = 1'b0;
    check("b2b_pulses", pulses, 4);
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
